// File: rtl/mem_ctl_host.sv
// mem_ctl_host: host-side burst initiator for the memory-controller request interface.
// Latency: command accept -> first req_valid 1 cycle; every output is registered.
// Backpressure: one beat in flight, held until din_ack; read beats also wait for dout_valid.
//
// Ports: cmd_* is the user command handshake. wr_data and wr_data_req form the user write-data
//   pop interface. rd_data and rd_data_valid carry returned read words. done and err report
//   the end of a burst. req_* and din_ack form the controller request handshake, and
//   dout/dout_valid return read data from the controller.
// Optional feature: define MEM_HOST_TIMEOUT_EN to abort a beat that waits TO_CYCLES cycles
//   without a response. The aborted burst ends with done and err strobed together.
//
// wr_data_req is asserted in the cycle after a write beat is acknowledged. The user must
// present the next word on wr_data before the end of that cycle, because the inter-beat
// gap cycle reloads req_data from wr_data.
module mem_ctl_host #(
    parameter int DW        = 8,
    parameter int AW        = 8,
    parameter int LW        = 4,
    parameter int TO_CYCLES = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic [DW-1:0] wr_data,
    output logic          wr_data_req,
    output logic [DW-1:0] rd_data,
    output logic          rd_data_valid,
    output logic          done,
    output logic          err,
    output logic          req_valid,
    output logic          req_wr,
    output logic [AW-1:0] req_addr,
    output logic [DW-1:0] req_data,
    input  logic          din_ack,
    input  logic [DW-1:0] dout,
    input  logic          dout_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RD,
        S_GAP,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          req_valid_q, req_valid_d;
    logic          req_wr_q, req_wr_d;
    logic [AW-1:0] req_addr_q, req_addr_d;
    logic [DW-1:0] req_data_q, req_data_d;
    logic [LW-1:0] beat_cnt_q, beat_cnt_d;
    logic          wr_data_req_q, wr_data_req_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_data_valid_q, rd_data_valid_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          last_beat;

`ifdef MEM_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          to_hit;
    assign to_hit = (to_cnt_q == TW'(TO_CYCLES - 1));
`endif

    assign last_beat = (beat_cnt_q == '0);

    always_comb begin
        state_d         = state_q;
        cmd_ready_d     = cmd_ready_q;
        req_valid_d     = req_valid_q;
        req_wr_d        = req_wr_q;
        req_addr_d      = req_addr_q;
        req_data_d      = req_data_q;
        beat_cnt_d      = beat_cnt_q;
        rd_data_d       = rd_data_q;
        wr_data_req_d   = 1'b0;
        rd_data_valid_d = 1'b0;
        err_d           = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = S_ISSUE;
                    cmd_ready_d = 1'b0;
                    req_valid_d = 1'b1;
                    req_wr_d    = cmd_wr;
                    req_addr_d  = cmd_addr;
                    beat_cnt_d  = cmd_len;
                    if (cmd_wr) begin
                        req_data_d = wr_data;
                    end
                end
            end
            S_ISSUE: begin
                if (din_ack) begin
                    req_valid_d = 1'b0;
                    if (req_wr_q) begin
                        wr_data_req_d = 1'b1;
                        state_d       = last_beat ? S_DONE : S_GAP;
                    end else if (dout_valid) begin
                        // Controller answered the read in the same cycle as the ack.
                        rd_data_d       = dout;
                        rd_data_valid_d = 1'b1;
                        state_d         = last_beat ? S_DONE : S_GAP;
                    end else begin
                        state_d = S_WAIT_RD;
                    end
                end
`ifdef MEM_HOST_TIMEOUT_EN
                else if (to_hit) begin
                    req_valid_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = S_DONE;
                end
`endif
            end
            S_WAIT_RD: begin
                if (dout_valid) begin
                    rd_data_d       = dout;
                    rd_data_valid_d = 1'b1;
                    state_d         = last_beat ? S_DONE : S_GAP;
                end
`ifdef MEM_HOST_TIMEOUT_EN
                else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
`endif
            end
            S_GAP: begin
                // One dead cycle between beats so req_valid never stays high across two requests.
                req_addr_d  = req_addr_q + AW'(1);
                beat_cnt_d  = beat_cnt_q - LW'(1);
                req_valid_d = 1'b1;
                if (req_wr_q) begin
                    req_data_d = wr_data;
                end
                state_d = S_ISSUE;
            end
            S_DONE: begin
                cmd_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
                req_valid_d = 1'b0;
            end
        endcase

        // DONE lasts exactly one cycle, so entering it is the done strobe.
        done_d = (state_d == S_DONE);
    end

`ifdef MEM_HOST_TIMEOUT_EN
    // Cleared on every entry into a waiting state, including ISSUE -> WAIT_RD.
    always_comb begin
        to_cnt_d = '0;
        if ((state_q == S_ISSUE || state_q == S_WAIT_RD) && (state_d == state_q)) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            cmd_ready_q     <= 1'b1;
            req_valid_q     <= 1'b0;
            req_wr_q        <= 1'b0;
            req_addr_q      <= '0;
            req_data_q      <= '0;
            beat_cnt_q      <= '0;
            wr_data_req_q   <= 1'b0;
            rd_data_q       <= '0;
            rd_data_valid_q <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            cmd_ready_q     <= cmd_ready_d;
            req_valid_q     <= req_valid_d;
            req_wr_q        <= req_wr_d;
            req_addr_q      <= req_addr_d;
            req_data_q      <= req_data_d;
            beat_cnt_q      <= beat_cnt_d;
            wr_data_req_q   <= wr_data_req_d;
            rd_data_q       <= rd_data_d;
            rd_data_valid_q <= rd_data_valid_d;
            done_q          <= done_d;
            err_q           <= err_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign req_valid     = req_valid_q;
    assign req_wr        = req_wr_q;
    assign req_addr      = req_addr_q;
    assign req_data      = req_data_q;
    assign wr_data_req   = wr_data_req_q;
    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_data_valid_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_mem_ctl_host.sv
// Testbench for mem_ctl_host: the bench acts as both user logic and memory controller.
// Expected request addresses and data come from the burst description: start + beat mod 256,
// plus a per-burst word table. Inputs are driven and outputs sampled on the falling edge.
module tb_mem_ctl_host;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_wr = 1'b0;
    logic [7:0] cmd_addr = '0;
    logic [3:0] cmd_len = '0;
    logic [7:0] wr_data = '0;
    logic       wr_data_req;
    logic [7:0] rd_data;
    logic       rd_data_valid;
    logic       done;
    logic       err;
    logic       req_valid;
    logic       req_wr;
    logic [7:0] req_addr;
    logic [7:0] req_data;
    logic       din_ack = 1'b0;
    logic [7:0] dout = '0;
    logic       dout_valid = 1'b0;

    int total = 0;
    int bad = 0;
    logic [7:0] pat [16];

    always #5 clk = ~clk;

    mem_ctl_host #(.DW(8), .AW(8), .LW(4), .TO_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_data_req(wr_data_req),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .done(done), .err(err),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data),
        .din_ack(din_ack), .dout(dout), .dout_valid(dout_valid)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) pat[i] = 8'($urandom);
    endtask

    // Runs one burst as user + controller. ack_dly/rd_dly < 0 pick random delays.
    // poke pulses a conflicting cmd_valid during beat 0; rst_at aborts with reset in ISSUE of that beat.
    task automatic burst(input bit wr, input logic [7:0] addr, input int len, input int ack_dly,
                         input int rd_dly, input bit same, input bit poke, input int rst_at);
        int dly;
        int rdl;
        check("cmd_ready_idle", 32'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_len = 4'(len);
        if (wr) wr_data = pat[0];
        tick();
        cmd_valid = 1'b0; cmd_addr = 8'($urandom); cmd_len = 4'($urandom); cmd_wr = ~wr;
        for (int b = 0; b <= len; b++) begin
            check("req_valid_issue", 32'(req_valid), 1);
            check("req_addr", 32'(req_addr), 32'(8'(addr + 8'(b))));
            check("req_wr", 32'(req_wr), 32'(wr));
            check("cmd_ready_busy", 32'(cmd_ready), 0);
            if (wr) check("req_data", 32'(req_data), 32'(pat[b]));
            if (b == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_req_valid", 32'(req_valid), 0);
                check("rst_done", 32'(done), 0);
                check("rst_err", 32'(err), 0);
                check("rst_wr_data_req", 32'(wr_data_req), 0);
                check("rst_cmd_ready", 32'(cmd_ready), 1);
                tick();
                rst_n = 1'b1;
                return;
            end
            dly = (ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly;
            for (int d = 0; d < dly; d++) begin
                cmd_valid = (poke && b == 0 && d == 0);
                if (cmd_valid) begin cmd_addr = 8'h55; cmd_wr = ~wr; end
                dout_valid = wr ? 1'($urandom) : 1'b0;
                tick();
                cmd_valid = 1'b0; dout_valid = 1'b0;
                check("hold_req_valid", 32'(req_valid), 1);
                check("hold_req_addr", 32'(req_addr), 32'(8'(addr + 8'(b))));
                check("hold_cmd_ready", 32'(cmd_ready), 0);
                if (wr) check("hold_rd_valid", 32'(rd_data_valid), 0);
            end
            din_ack = 1'b1;
            if (!wr && same) begin dout_valid = 1'b1; dout = pat[b]; end
            tick();
            din_ack = 1'b0; dout_valid = 1'b0;
            check("ack_req_valid_low", 32'(req_valid), 0);
            if (wr) begin
                check("wr_data_req", 32'(wr_data_req), 1);
                check("wr_rd_valid", 32'(rd_data_valid), 0);
                if (b < len) wr_data = pat[b+1];
            end else if (!same) begin
                rdl = (rd_dly < 0) ? int'($urandom_range(0, 3)) : rd_dly;
                for (int k = 0; k < rdl; k++) begin
                    check("wait_req_valid", 32'(req_valid), 0);
                    check("wait_rd_valid", 32'(rd_data_valid), 0);
                    din_ack = 1'($urandom);
                    tick();
                    din_ack = 1'b0;
                end
                check("wait_req_valid_end", 32'(req_valid), 0);
                dout_valid = 1'b1; dout = pat[b];
                tick();
                dout_valid = 1'b0; dout = 8'($urandom);
                check("rd_data_valid", 32'(rd_data_valid), 1);
                check("rd_data", 32'(rd_data), 32'(pat[b]));
                check("rd_req_valid_low", 32'(req_valid), 0);
            end else begin
                check("rd_same_valid", 32'(rd_data_valid), 1);
                check("rd_same_data", 32'(rd_data), 32'(pat[b]));
            end
            if (b == len) begin
                check("done_last", 32'(done), 1);
                check("err_last", 32'(err), 0);
                tick();
                check("idle_done_low", 32'(done), 0);
                check("idle_cmd_ready", 32'(cmd_ready), 1);
                check("idle_wr_data_req", 32'(wr_data_req), 0);
                check("idle_rd_valid", 32'(rd_data_valid), 0);
            end else begin
                check("gap_done_low", 32'(done), 0);
                check("gap_req_valid", 32'(req_valid), 0);
                tick();
            end
        end
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("reset_cmd_ready", 32'(cmd_ready), 1);
        check("reset_req_valid", 32'(req_valid), 0);
        check("reset_done", 32'(done), 0);
        check("reset_err", 32'(err), 0);
        check("reset_rd_valid", 32'(rd_data_valid), 0);
        check("reset_wr_data_req", 32'(wr_data_req), 0);
        check("reset_req_addr", 32'(req_addr), 0);
        check("reset_rd_data", 32'(rd_data), 0);
        rst_n = 1'b1;
        tick();

        // Directed write: three beats, ack two cycles after request
        pat[0] = 8'hA1; pat[1] = 8'hA2; pat[2] = 8'hA3;
        burst(1'b1, 8'h10, 2, 2, 0, 1'b0, 1'b0, -1);

        // Directed read: two beats, data a few cycles after each ack
        pat[0] = 8'h5A; pat[1] = 8'hC3;
        burst(1'b0, 8'h20, 1, 1, 2, 1'b0, 1'b0, -1);

        // Single-beat read answered in the ack cycle
        tick();
        pat[0] = 8'h77;
        burst(1'b0, 8'h40, 0, 0, 0, 1'b1, 1'b0, -1);

        // Address wrap with an ignored mid-burst command
        fill_random();
        burst(1'b1, 8'hFF, 1, 2, 0, 1'b0, 1'b1, -1);

        // Reset during the second beat, then a clean write burst
        fill_random();
        burst(1'b1, 8'h30, 2, 1, 0, 1'b0, 1'b0, 1);
        check("post_rst_cmd_ready", 32'(cmd_ready), 1);
        check("post_rst_req_valid", 32'(req_valid), 0);
        fill_random();
        burst(1'b1, 8'h31, 2, -1, 0, 1'b0, 1'b0, -1);

        // Randomized bursts
        for (int n = 0; n < 8; n++) begin
            fill_random();
            burst(1'($urandom), 8'($urandom), int'($urandom_range(0, 5)), -1, -1,
                  1'($urandom), 1'b0, -1);
            if ($urandom_range(0, 1) == 1) tick();
        end

        // Controller never acknowledges
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h80; cmd_len = 4'd0;
        tick();
        cmd_valid = 1'b0;
`ifdef MEM_HOST_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            check("to_req_valid", 32'(req_valid), 1);
            check("to_done_low", 32'(done), 0);
            tick();
        end
        check("to_req_valid_drop", 32'(req_valid), 0);
        check("to_done", 32'(done), 1);
        check("to_err", 32'(err), 1);
        tick();
        check("to_idle_ready", 32'(cmd_ready), 1);
        check("to_idle_err", 32'(err), 0);
`else
        for (int i = 0; i < 110; i++) begin
            check("noto_req_valid", 32'(req_valid), 1);
            check("noto_err", 32'(err), 0);
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("noto_rst_ready", 32'(cmd_ready), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
